// File: rtl/dirty_mem_dumper.sv
// rtl/dirty_mem_dumper.sv - scans the dirty-bit tracker and streams {addr, data} of every dirty word
module dirty_mem_dumper #(
  parameter int N_ELEMENTS = 128,
  parameter int ADDRWIDTH  = $clog2(N_ELEMENTS),
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic [ADDRWIDTH-1:0]  dirty_addr_o,
  input  logic                  dirty_bit_i,
  output logic [ADDRWIDTH-1:0]  mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [ADDRWIDTH-1:0]  tx_addr_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDRWIDTH:0]    dirty_count_o
);

  typedef enum logic [2:0] {IDLE, SCAN, READ, SEND, DONE} state_t;

  localparam logic [ADDRWIDTH-1:0] LAST_IDX = ADDRWIDTH'(N_ELEMENTS - 1);

  state_t               state;
  logic [ADDRWIDTH-1:0] idx;

  // Tracker and memory are both addressed by the scan index; memory data returns one cycle later.
  assign dirty_addr_o = idx;
  assign mem_addr_o   = idx;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state         <= IDLE;
      idx           <= '0;
      tx_valid_o    <= 1'b0;
      tx_addr_o     <= '0;
      tx_data_o     <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      dirty_count_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            idx           <= '0;
            dirty_count_o <= '0;
            busy_o        <= 1'b1;
            state         <= SCAN;
          end
        end
        SCAN: begin
          if (dirty_bit_i) begin
            state <= READ;
          end else if (idx == LAST_IDX) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + ADDRWIDTH'(1);
          end
        end
        READ: begin
          tx_data_o  <= mem_data_i;
          tx_addr_o  <= idx;
          tx_valid_o <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          // Record stays on the bus, unchanged, until the consumer takes it.
          if (tx_ready_i) begin
            tx_valid_o    <= 1'b0;
            dirty_count_o <= dirty_count_o + (ADDRWIDTH + 1)'(1);
            if (idx == LAST_IDX) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              idx   <= idx + ADDRWIDTH'(1);
              state <= SCAN;
            end
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dirty_mem_dumper.sv
// tb/tb_dirty_mem_dumper.sv - directed scoreboard bench for dirty_mem_dumper
module tb_dirty_mem_dumper;

  localparam int N  = 128;
  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] dirty_addr;
  logic          dirty_bit;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [AW-1:0] tx_addr;
  logic [DW-1:0] tx_data;
  logic          busy;
  logic          done;
  logic [AW:0]   dirty_count;

  logic [DW-1:0] mem [N];
  logic          dirty [N];
  logic [AW+DW-1:0] exp_q [$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign dirty_bit = dirty[dirty_addr];
  always_ff @(posedge clk) mem_data <= mem[mem_addr];

  dirty_mem_dumper #(.N_ELEMENTS(N), .ADDRWIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock_i       (clk),
    .reset_i       (reset),
    .start_i       (start),
    .dirty_addr_o  (dirty_addr),
    .dirty_bit_i   (dirty_bit),
    .mem_addr_o    (mem_addr),
    .mem_data_i    (mem_data),
    .tx_valid_o    (tx_valid),
    .tx_ready_i    (tx_ready),
    .tx_addr_o     (tx_addr),
    .tx_data_o     (tx_data),
    .busy_o        (busy),
    .done_o        (done),
    .dirty_count_o (dirty_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_dirty();
    for (int i = 0; i < N; i++) dirty[i] = 1'b0;
  endtask

  task automatic mark_dirty(input int a);
    dirty[a] = 1'b1;
    exp_q.push_back({AW'(a), mem[a]});
  endtask

  // Pulses start, services the stream with an optional initial stall, and
  // checks every record against the scoreboard plus done timing and count.
  task automatic run_dump(input string tag, input int stall, input int extra_start_at,
                          input int exp_cycles, input int exp_count);
    int  stall_left;
    int  cyc;
    bit  finished;
    logic [AW+DW-1:0] e;
    stall_left = stall;
    finished   = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    while (!finished && cyc <= 2000) begin
      start = (cyc == extra_start_at);
      if (done) begin
        finished = 1'b1;
        chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cycles));
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd1);
        chk({tag, "_count"}, 64'(dirty_count), 64'(exp_count));
        chk({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
      end else begin
        if (!busy) chk({tag, "_busy"}, 64'(busy), 64'd1);
        if (tx_valid) begin
          if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_record"}, 64'(tx_addr), 64'hFFFF);
            tx_ready = 1'b1;
          end else begin
            e = exp_q[0];
            if (stall_left > 0) begin
              tx_ready = 1'b0;
              stall_left--;
              chk({tag, "_stall_addr"}, 64'(tx_addr), 64'(e[AW+DW-1:DW]));
              chk({tag, "_stall_data"}, 64'(tx_data), 64'(e[DW-1:0]));
            end else begin
              tx_ready = 1'b1;
              void'(exp_q.pop_front());
              chk({tag, "_rec_addr"}, 64'(tx_addr), 64'(e[AW+DW-1:DW]));
              chk({tag, "_rec_data"}, 64'(tx_data), 64'(e[DW-1:0]));
            end
          end
        end else begin
          tx_ready = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!finished) chk({tag, "_timeout"}, 64'(cyc), 64'(exp_cycles));
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_done"}, 64'(done), 64'd0);
    chk({tag, "_count_held"}, 64'(dirty_count), 64'(exp_count));
    exp_q.delete();
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < N; i++) mem[i] = 32'hD0000000 ^ (i * 32'h00010203) ^ 32'h5A5A;
    clear_dirty();
    reset    = 1'b1;
    start    = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    chk("rst_valid", 64'(tx_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(dirty_count), 64'd0);
    chk("rst_addr", 64'(tx_addr), 64'd0);
    chk("rst_data", 64'(tx_data), 64'd0);
    chk("rst_idx", 64'(dirty_addr), 64'd0);

    // all clean: done in cycle 1+N after start
    run_dump("clean", 0, 0, 1 + N, 0);

    clear_dirty();
    mark_dirty(0); mark_dirty(1); mark_dirty(5); mark_dirty(127);
    run_dump("sparse", 0, 0, 1 + N + 8, 4);

    clear_dirty();
    mark_dirty(3);
    run_dump("stall", 10, 0, 1 + N + 2 + 10, 1);

    clear_dirty();
    for (int i = 0; i < N; i++) mark_dirty(i);
    run_dump("all", 0, 0, 1 + N + 2 * N, N);

    // reset while addr 5 is pending, after addr 2 was already sent
    clear_dirty();
    dirty[2] = 1'b1;
    dirty[5] = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (tx_valid && tx_addr == AW'(5)) begin
        hit = 1'b1;
        tx_ready = 1'b0;
      end else begin
        tx_ready = 1'b1;
        @(negedge clk);
      end
    end
    chk("rstmid_reached", 64'(hit), 64'd1);
    chk("rstmid_data", 64'(tx_data), 64'(mem[5]));
    chk("rstmid_count_before", 64'(dirty_count), 64'd1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("rstmid_valid", 64'(tx_valid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_count", 64'(dirty_count), 64'd0);
    repeat (3) @(negedge clk);
    chk("rstmid_stays_idle", 64'(busy), 64'd0);

    // start pulsed while busy is ignored
    clear_dirty();
    mark_dirty(10); mark_dirty(20);
    run_dump("busy_start", 0, 30, 1 + N + 4, 2);

    // fresh start after done clears the count and rescans everything
    clear_dirty();
    mark_dirty(64);
    run_dump("rescan", 0, 0, 1 + N + 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
